// File: rtl/dsc_pkg.sv
// Shared types for the DSC front end: colour mode, per-pixel slice tags, ingest FSM states.
`timescale 1ns/1ps
package dsc_pkg;

    typedef enum logic {
        COLOR_RGB   = 1'b0,
        COLOR_YCoCg = 1'b1
    } color_e;

    typedef struct packed {
        logic sol;
        logic eol;
        logic sos;
        logic eos;
        logic eof;
    } dsc_pix_tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ingest_state_e;

endpackage

// File: rtl/dsc_ycocg_pipe.sv
// Two-stage RGB->YCoCg-R (or RGB pass-through) with tag carry; 2 clk latency, full throughput.
// Valid/ready per stage with bubble collapse; outputs hold while out_valid & ~out_ready.
`timescale 1ns/1ps
module dsc_ycocg_pipe
    import dsc_pkg::*;
#(
    parameter int BPC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ycocg,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BPC-1:0]     in_r,
    input  logic [BPC-1:0]     in_g,
    input  logic [BPC-1:0]     in_b,
    input  dsc_pix_tag_t       in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BPC-1:0]     out_c0,
    output logic [BPC:0]       out_c1,
    output logic [BPC:0]       out_c2,
    output dsc_pix_tag_t       out_tag,
    output logic               empty
);

    localparam logic [BPC:0] OFS = {1'b1, {BPC{1'b0}}};

    logic signed [BPC:0] r_s, b_s, co, t;
    logic signed [BPC:0] s1_x, s1_y;
    logic [BPC-1:0]      s1_g;
    logic                s1_mode, s1_vld, s2_rdy;
    dsc_pix_tag_t        s1_tag;

    logic signed [BPC:0] g2, cg;
    logic [BPC-1:0]      c0_nxt;
    logic [BPC:0]        c1_nxt, c2_nxt;

    assign r_s = $signed({1'b0, in_r});
    assign b_s = $signed({1'b0, in_b});
    assign co  = r_s - b_s;
    assign t   = b_s + (co >>> 1);

    assign s2_rdy   = ~out_valid | out_ready;
    assign in_ready = ~s1_vld | s2_rdy;
    assign empty    = ~s1_vld & ~out_valid;

    // Stage 1 keeps (t, Co) for YCoCg, or (R, B) for pass-through, in the same registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_mode <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_g    <= '0;
            s1_tag  <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_mode <= ycocg;
                s1_x    <= ycocg ? t  : $signed({1'b0, in_r});
                s1_y    <= ycocg ? co : $signed({1'b0, in_b});
                s1_g    <= in_g;
                s1_tag  <= in_tag;
            end
        end
    end

    assign g2     = $signed({1'b0, s1_g});
    assign cg     = g2 - s1_x;
    assign c0_nxt = s1_mode ? BPC'(s1_x + (cg >>> 1)) : s1_x[BPC-1:0];
    assign c1_nxt = s1_mode ? (s1_y + OFS) : {1'b0, s1_g};
    assign c2_nxt = s1_mode ? (cg + OFS)   : s1_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_c0    <= '0;
            out_c1    <= '0;
            out_c2    <= '0;
            out_tag   <= '0;
        end else if (s2_rdy) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_c0  <= c0_nxt;
                out_c1  <= c1_nxt;
                out_c2  <= c2_nxt;
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: rtl/dsc_pix_ingest.sv
// Raster pixel ingest: frame FSM, slice-geometry counters/tags, feeds the 2-stage colour pipe.
// Latency 2 clk unstalled; in_ready only in RUN and follows pipe backpressure combinationally.
`timescale 1ns/1ps
module dsc_pix_ingest
    import dsc_pkg::*;
#(
    parameter int BPC   = 8,
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_color,
    input  logic [DIM_W-1:0] cfg_pic_w,
    input  logic [DIM_W-1:0] cfg_pic_h,
    input  logic [DIM_W-1:0] cfg_slice_w,
    input  logic [DIM_W-1:0] cfg_slice_h,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BPC-1:0]   in_r,
    input  logic [BPC-1:0]   in_g,
    input  logic [BPC-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BPC-1:0]   out_c0,
    output logic [BPC:0]     out_c1,
    output logic [BPC:0]     out_c2,
    output logic             out_sol,
    output logic             out_eol,
    output logic             out_sos,
    output logic             out_eos,
    output logic             out_eof,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);

    localparam logic [DIM_W-1:0] ONE = 1;

    ingest_state_e    state, state_nxt;
    color_e           color_q;
    logic [DIM_W-1:0] pic_w_q, pic_h_q, slice_w_q, slice_h_q;
    logic [DIM_W-1:0] pic_x, pic_y, sx, sy;
    logic             cfg_ok, start_idle, start_ok, in_fire;
    logic             last_col, last_row, last_sx, last_sy;
    logic             pipe_ready, pipe_empty;
    dsc_pix_tag_t     tag, out_tag;

    assign cfg_ok = (cfg_pic_w != '0) && (cfg_pic_h != '0) &&
                    (cfg_slice_w != '0) && (cfg_slice_h != '0) &&
                    (cfg_slice_w <= cfg_pic_w) && (cfg_slice_h <= cfg_pic_h);
    assign start_idle = start && (state == IDLE);
    assign start_ok   = start_idle && cfg_ok;
    assign in_fire    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (in_fire && tag.eof) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == RUN) && pipe_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q   <= COLOR_RGB;
            pic_w_q   <= '0;
            pic_h_q   <= '0;
            slice_w_q <= '0;
            slice_h_q <= '0;
            cfg_err   <= 1'b0;
        end else if (start_idle) begin
            if (cfg_ok) begin
                color_q   <= color_e'(cfg_color);
                pic_w_q   <= cfg_pic_w;
                pic_h_q   <= cfg_pic_h;
                slice_w_q <= cfg_slice_w;
                slice_h_q <= cfg_slice_h;
                cfg_err   <= 1'b0;
            end else begin
                cfg_err   <= 1'b1;
            end
        end
    end

    assign last_col = (pic_x == pic_w_q - ONE);
    assign last_row = (pic_y == pic_h_q - ONE);
    assign last_sx  = (sx == slice_w_q - ONE);
    assign last_sy  = (sy == slice_h_q - ONE);

    assign tag.sol = (sx == '0);
    assign tag.eol = last_sx || last_col;
    assign tag.sos = tag.sol && (sy == '0);
    assign tag.eos = tag.eol && (last_sy || last_row);
    assign tag.eof = last_col && last_row;

    // The picture edge also closes a slice, so a narrower last column/row slice needs no extra state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pic_x <= '0;
            pic_y <= '0;
            sx    <= '0;
            sy    <= '0;
        end else if (start_ok) begin
            pic_x <= '0;
            pic_y <= '0;
            sx    <= '0;
            sy    <= '0;
        end else if (in_fire) begin
            if (last_col) begin
                pic_x <= '0;
                sx    <= '0;
                pic_y <= last_row ? '0 : pic_y + ONE;
                sy    <= (last_sy || last_row) ? '0 : sy + ONE;
            end else begin
                pic_x <= pic_x + ONE;
                sx    <= last_sx ? '0 : sx + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= out_valid && out_ready && out_tag.eof;
    end

    dsc_ycocg_pipe #(.BPC(BPC)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .ycocg     (color_q == COLOR_YCoCg),
        .in_valid  (in_fire),
        .in_ready  (pipe_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_tag    (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c0    (out_c0),
        .out_c1    (out_c1),
        .out_c2    (out_c2),
        .out_tag   (out_tag),
        .empty     (pipe_empty)
    );

    assign out_sol = out_tag.sol;
    assign out_eol = out_tag.eol;
    assign out_sos = out_tag.sos;
    assign out_eos = out_tag.eos;
    assign out_eof = out_tag.eof;

endmodule

// File: tb/tb_dsc_pix_ingest.sv
// Directed bench for dsc_pix_ingest: transform vectors, slice tags, stalls, cfg errors, mid-frame reset.
`timescale 1ns/1ps
module tb_dsc_pix_ingest;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cfg_color = 1'b0;
    logic [15:0] cfg_pic_w = '0, cfg_pic_h = '0, cfg_slice_w = '0, cfg_slice_h = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_c0;
    logic [8:0]  out_c1, out_c2;
    logic        out_sol, out_eol, out_sos, out_eos, out_eof;
    logic        busy, frame_done, cfg_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  pr [512];
    logic [7:0]  pg [512];
    logic [7:0]  pb [512];
    logic [30:0] exp_q [$];

    always #5 clk = ~clk;

    dsc_pix_ingest #(.BPC(8), .DIM_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_color(cfg_color),
        .cfg_pic_w(cfg_pic_w), .cfg_pic_h(cfg_pic_h),
        .cfg_slice_w(cfg_slice_w), .cfg_slice_h(cfg_slice_h),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2),
        .out_sol(out_sol), .out_eol(out_eol), .out_sos(out_sos),
        .out_eos(out_eos), .out_eof(out_eof),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int half(input int v);
        return (v - (v & 1)) / 2;
    endfunction

    function automatic logic [30:0] model(input bit col, input int r, input int g, input int b,
                                          input int x, input int y, input int pw, input int ph,
                                          input int sw, input int sh);
        int co, t, cg, yy, c0, c1, c2;
        bit sol, eol, sos, eos, eof;
        if (col) begin
            co = r - b;  t  = b + half(co);
            cg = g - t;  yy = t + half(cg);
            c0 = yy;     c1 = co + 256;  c2 = cg + 256;
        end else begin
            c0 = r;  c1 = g;  c2 = b;
        end
        sol = (x % sw) == 0;
        eol = ((x % sw) == sw - 1) || (x == pw - 1);
        sos = sol && ((y % sh) == 0);
        eos = eol && (((y % sh) == sh - 1) || (y == ph - 1));
        eof = (x == pw - 1) && (y == ph - 1);
        return {c0[7:0], c1[8:0], c2[8:0], sol, eol, sos, eos, eof};
    endfunction

    task automatic do_start(input int pw, input int ph, input int sw, input int sh, input bit col);
        @(posedge clk); #1;
        cfg_pic_w = 16'(pw);   cfg_pic_h = 16'(ph);
        cfg_slice_w = 16'(sw); cfg_slice_h = 16'(sh);
        cfg_color = col;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic one_pix(input string nm, input bit col, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic [7:0] e0, input logic [8:0] e1,
                           input logic [8:0] e2);
        do_start(1, 1, 1, 1, col);
        @(posedge clk); #1;
        in_valid = 1'b1; in_r = r; in_g = g; in_b = b; out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_lat2_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_pix"}, {1'b0, out_c0, out_c1, out_c2, out_sol, out_eol, out_sos, out_eos, out_eof},
              {1'b0, e0, e1, e2, 5'b11111});
        @(negedge clk);
        check({nm, "_frame_done"}, 32'(frame_done), 32'd1);
        check({nm, "_drained"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_idle"}, {30'd0, busy, frame_done}, 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input int pw, input int ph, input int sw, input int sh, input bit col,
                             input bit rnd, output int n_eol, output int n_eos, output int n_eof);
        int npix, sent, recv, cyc, n_done;
        logic [30:0] obs_w, prev_w;
        bit stalled;
        npix = pw * ph;
        for (int i = 0; i < npix; i++) begin
            pr[i] = 8'($urandom_range(0, 255));
            pg[i] = 8'($urandom_range(0, 255));
            pb[i] = 8'($urandom_range(0, 255));
        end
        exp_q.delete();
        n_eol = 0; n_eos = 0; n_eof = 0; n_done = 0;
        sent = 0; recv = 0; cyc = 0; stalled = 1'b0; prev_w = '0;
        do_start(pw, ph, sw, sh, col);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cfg_err", 32'(cfg_err), 32'd0);
        while ((recv < npix || busy) && cyc < 5000) begin
            @(posedge clk); #1;
            in_valid  = (sent < npix) && (!rnd || $urandom_range(0, 1) == 1);
            out_ready = !rnd || ($urandom_range(0, 1) == 1);
            if (sent < npix) begin
                in_r = pr[sent]; in_g = pg[sent]; in_b = pb[sent];
            end
            @(negedge clk);
            cyc++;
            if (frame_done) n_done++;
            obs_w = {out_c0, out_c1, out_c2, out_sol, out_eol, out_sos, out_eos, out_eof};
            if (stalled) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_data", 32'(obs_w), 32'(prev_w));
            end
            if (out_valid && out_ready) begin
                check("out_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("pix", 32'(obs_w), 32'(exp_q.pop_front()));
                end
                recv++;
                n_eol += int'(out_eol);
                n_eos += int'(out_eos);
                n_eof += int'(out_eof);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(col, int'(pr[sent]), int'(pg[sent]), int'(pb[sent]),
                                      sent % pw, sent / pw, pw, ph, sw, sh));
                sent++;
            end
            stalled = out_valid && !out_ready;
            prev_w  = obs_w;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("frame_in_time", 32'(cyc < 5000), 32'd1);
        check("recv_count", 32'(recv), 32'(npix));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("frame_done_count", 32'(n_done), 32'd1);
        if (!rnd) check("full_throughput", 32'(cyc <= npix + 5), 32'd1);
    endtask

    initial begin
        int n_eol, n_eos, n_eof;

        // Reset state
        @(negedge clk);
        check("rst_ctrl", {26'd0, in_ready, out_valid, busy, frame_done, cfg_err, out_eof},  32'd0);
        check("rst_data", {1'b0, out_c0, out_c1, out_c2, out_sol, out_eol, out_sos, out_eos, out_eof}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pixels offered in IDLE are not taken
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Transform vectors
        one_pix("ycocg_a", 1'b1, 8'd200, 8'd100, 8'd50,  8'd112, 9'd406, 9'd231);
        one_pix("ycocg_b", 1'b1, 8'd0,   8'd255, 8'd255, 8'd191, 9'd1,   9'd384);
        one_pix("ycocg_c", 1'b1, 8'd255, 8'd0,   8'd0,   8'd63,  9'd511, 9'd129);
        one_pix("rgb_max", 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 9'd255, 9'd255);
        one_pix("rgb_zero", 1'b0, 8'd0,  8'd0,   8'd0,   8'd0,   9'd0,   9'd0);

        // 10x4 picture, 4x2 slices, unstalled
        run_frame(10, 4, 4, 2, 1'b1, 1'b0, n_eol, n_eos, n_eof);
        check("g10x4_eol_count", 32'(n_eol), 32'd12);
        check("g10x4_eos_count", 32'(n_eos), 32'd6);
        check("g10x4_eof_count", 32'(n_eof), 32'd1);

        // Rejected configurations
        do_start(10, 4, 0, 2, 1'b1);
        check("err_slice_w0", {29'd0, cfg_err, busy, in_ready}, {29'd0, 3'b100});
        do_start(4, 4, 8, 2, 1'b0);
        check("err_slice_gt_pic", {29'd0, cfg_err, busy, in_ready}, {29'd0, 3'b100});
        run_frame(10, 4, 4, 2, 1'b0, 1'b1, n_eol, n_eos, n_eof);
        check("err_clear_eof", 32'(n_eof), 32'd1);

        // 64x8 random stalls, narrower last slice column and row
        run_frame(64, 8, 24, 3, 1'b1, 1'b1, n_eol, n_eos, n_eof);
        check("g64x8_eol_count", 32'(n_eol), 32'd24);
        check("g64x8_eos_count", 32'(n_eos), 32'd9);
        check("g64x8_eof_count", 32'(n_eof), 32'd1);

        // Reset with a pixel waiting at the output
        do_start(64, 8, 16, 4, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_r = 8'd10; in_g = 8'd20; in_b = 8'd30; out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {28'd0, out_valid, busy, in_ready, frame_done}, 32'd0);
        check("mid_rst_c0", 32'(out_c0), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(64, 8, 16, 4, 1'b1, 1'b1, n_eol, n_eos, n_eof);
        check("post_rst_eos_count", 32'(n_eos), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
